// File: rtl/div_pkg.sv
// Shared definitions for the iterative signed/unsigned divider.
package div_pkg;

    // Widest operand the magnitude helper supports; divider instances need n <= DIV_MAX_W.
    localparam int DIV_MAX_W = 64;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BUSY,
        DIV_DONE
    } div_state_t;

    // Conditional two's-complement negate. Callers zero-extend their n-bit value into
    // DIV_MAX_W bits and truncate the result back to n bits. The low n bits of a
    // wide negate equal the n-bit negate, so one function serves every width.
    function automatic logic [DIV_MAX_W-1:0] abs_n(input logic [DIV_MAX_W-1:0] x,
                                                   input logic                 neg);
        return neg ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/udiv_step.sv
// One restoring-division step.
// The partial remainder shifts left and takes in the next dividend bit, then the
// divisor is trial-subtracted. If the result is non-negative it is kept.
module udiv_step #(
    parameter int n = 8
) (
    input  logic [n:0]   rem_in,
    input  logic         dvd_bit,
    input  logic [n-1:0] divisor,
    output logic [n:0]   rem_out,
    output logic         quo_bit
);

    logic [n+1:0] shifted;
    logic [n+1:0] diff;

    // Shift, trial-subtract, and keep the difference when it is non-negative.
    // The extra top bit keeps the borrow visible even when the shifted remainder
    // uses all n+1 bits.
    always_comb begin
        shifted = {rem_in, dvd_bit};
        diff    = shifted - {2'b00, divisor};
        quo_bit = ~diff[n+1];
        rem_out = quo_bit ? diff[n:0] : shifted[n:0];
    end

endmodule

// File: rtl/signed_or_unsigned_div.sv
// Iterative radix-2 divider with valid/ready handshakes on the argument and result sides.
// The divider produces one quotient bit per clock and works on magnitudes.
// The signs are restored on the final BUSY edge, so the DONE outputs come straight from registers.
module signed_or_unsigned_div
    import div_pkg::*;
#(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         arg_vld,
    output logic         arg_rdy,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         signed_div,
    output logic         res_vld,
    input  logic         res_rdy,
    output logic [n-1:0] quo,
    output logic [n-1:0] rem,
    output logic         div_by_zero
);

    localparam int CNT_W = $clog2(n);

    div_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [n:0]     prem_q;      // partial remainder
    logic [n-1:0]   dvd_q;       // dividend bits shift out of the MSB, quotient bits shift in at the LSB
    logic [n-1:0]   mag_b_q;     // |b|
    logic           neg_quo_q;   // negate the quotient at the end
    logic           neg_rem_q;   // negate the remainder at the end
    logic           zero_q;      // b was zero
    logic [n-1:0]   quo_q, rem_q;
    logic           dz_q;

    logic [n-1:0]   a_mag, b_mag;
    logic [n:0]     step_rem;
    logic           step_quo;
    logic [n-1:0]   quo_next;

    // Magnitudes are taken only for signed transactions.
    // The most-negative value maps to 2^(n-1), which still fits in n unsigned bits.
    assign a_mag    = n'(abs_n(DIV_MAX_W'(a), signed_div & a[n-1]));
    assign b_mag    = n'(abs_n(DIV_MAX_W'(b), signed_div & b[n-1]));
    assign quo_next = {dvd_q[n-2:0], step_quo};

    udiv_step #(.n(n)) u_step (
        .rem_in  (prem_q),
        .dvd_bit (dvd_q[n-1]),
        .divisor (mag_b_q),
        .rem_out (step_rem),
        .quo_bit (step_quo)
    );

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= DIV_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and handshake outputs.
    // NOTE: every output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        arg_rdy = 1'b0;
        res_vld = 1'b0;
        unique case (state_q)
            DIV_IDLE: begin
                arg_rdy = 1'b1;
                if (arg_vld) state_d = DIV_BUSY;
            end
            DIV_BUSY: begin
                if (cnt_q == '0) state_d = DIV_DONE;
            end
            DIV_DONE: begin
                res_vld = 1'b1;
                if (res_rdy) state_d = DIV_IDLE;
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    // Datapath: capture on accept, step each BUSY cycle, apply the sign fix-up on the last step.
    // Results hold through DONE and IDLE until the next transaction completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            prem_q    <= '0;
            dvd_q     <= '0;
            mag_b_q   <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            zero_q    <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            dz_q      <= 1'b0;
        end else begin
            unique case (state_q)
                DIV_IDLE: begin
                    if (arg_vld) begin
                        cnt_q     <= CNT_W'(n - 1);
                        prem_q    <= '0;
                        dvd_q     <= a_mag;
                        mag_b_q   <= b_mag;
                        neg_quo_q <= signed_div & (a[n-1] ^ b[n-1]);
                        neg_rem_q <= signed_div & a[n-1];
                        zero_q    <= (b == '0);
                    end
                end
                DIV_BUSY: begin
                    prem_q <= step_rem;
                    dvd_q  <= quo_next;
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        // Divide by zero reports all ones regardless of sign. The remainder
                        // path already reproduces a, because every trial subtraction of zero succeeds.
                        quo_q <= zero_q ? '1 : n'(abs_n(DIV_MAX_W'(quo_next), neg_quo_q));
                        rem_q <= n'(abs_n(DIV_MAX_W'(step_rem[n-1:0]), neg_rem_q));
                        dz_q  <= zero_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign quo         = quo_q;
    assign rem         = rem_q;
    assign div_by_zero = dz_q;

endmodule

// File: tb/tb_signed_or_unsigned_div.sv
// Self-checking bench for signed_or_unsigned_div.
// It uses directed cases and random cases at n=8 and n=4.
// Expected results come from a reference model built on the / and % operators and
// are queued when each transaction is driven.
module tb_signed_or_unsigned_div;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       vld8 = 1'b0, rdy8, sd8 = 1'b0, rvld8, rrdy8 = 1'b1, dz8;
    logic [7:0] a8 = '0, b8 = '0, quo8, rem8;
    logic       vld4 = 1'b0, rdy4, sd4 = 1'b0, rvld4, rrdy4 = 1'b1, dz4;
    logic [3:0] a4 = '0, b4 = '0, quo4, rem4;

    int         sel = 8;
    logic       obs_vld, obs_rdy, obs_dz;
    logic [7:0] obs_quo, obs_rem;

    int         errors = 0;
    int         checks = 0;
    exp_t       scb[$];

    always #5 clk = ~clk;

    signed_or_unsigned_div #(.n(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .arg_vld(vld8), .arg_rdy(rdy8), .a(a8), .b(b8),
        .signed_div(sd8), .res_vld(rvld8), .res_rdy(rrdy8), .quo(quo8), .rem(rem8),
        .div_by_zero(dz8)
    );

    signed_or_unsigned_div #(.n(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .arg_vld(vld4), .arg_rdy(rdy4), .a(a4), .b(b4),
        .signed_div(sd4), .res_vld(rvld4), .res_rdy(rrdy4), .quo(quo4), .rem(rem4),
        .div_by_zero(dz4)
    );

    // Route the selected instance's outputs to one set of observation signals.
    always_comb begin
        if (sel == 8) begin
            obs_vld = rvld8; obs_rdy = rdy8; obs_dz = dz8;
            obs_quo = quo8;  obs_rem = rem8;
        end else begin
            obs_vld = rvld4; obs_rdy = rdy4; obs_dz = dz4;
            obs_quo = {4'b0, quo4}; obs_rem = {4'b0, rem4};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: SV integer / and % truncate toward zero, and the remainder follows the dividend.
    function automatic exp_t ref_div(input int w, input logic [7:0] a, input logic [7:0] b,
                                     input logic s);
        exp_t e;
        int mask = (1 << w) - 1;
        int ua = int'(a) & mask;
        int ub = int'(b) & mask;
        int sa = (s && ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
        int sbv = (s && ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
        int q, r;
        if (ub == 0) begin
            q = -1;
            r = sa;
        end else begin
            q = sa / sbv;
            r = sa % sbv;
        end
        e.q  = 8'(q & mask);
        e.r  = 8'(r & mask);
        e.dz = (ub == 0);
        return e;
    endfunction

    task automatic start(input logic [7:0] a, input logic [7:0] b, input logic s);
        @(negedge clk);
        check("arg_rdy before accept", {31'b0, obs_rdy}, 32'd1);
        if (sel == 8) begin
            a8 = a; b8 = b; sd8 = s; vld8 = 1'b1;
        end else begin
            a4 = a[3:0]; b4 = b[3:0]; sd4 = s; vld4 = 1'b1;
        end
        scb.push_back(ref_div(sel, a, b, s));
    endtask

    // The count includes the accept edge itself. The result is due on edge n+1.
    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            vld8 = 1'b0;
            vld4 = 1'b0;
            lat++;
        end while (!obs_vld && lat < 40);
    endtask

    task automatic check_result(input string tag, output exp_t e);
        if (scb.size() != 0) e = scb.pop_front();
        else e = '{q: 8'hxx, r: 8'hxx, dz: 1'bx};
        check({tag, " res_vld"}, {31'b0, obs_vld}, 32'd1);
        check({tag, " quo"}, {24'b0, obs_quo}, {24'b0, e.q});
        check({tag, " rem"}, {24'b0, obs_rem}, {24'b0, e.r});
        check({tag, " div_by_zero"}, {31'b0, obs_dz}, {31'b0, e.dz});
    endtask

    task automatic run(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input string tag);
        int   lat;
        exp_t e;
        start(a, b, s);
        wait_result(lat);
        check({tag, " latency"}, lat, sel + 1);
        check_result(tag, e);
        @(posedge clk);
        #1;
        check({tag, " handoff res_vld"}, {31'b0, obs_vld}, 32'd0);
        check({tag, " handoff arg_rdy"}, {31'b0, obs_rdy}, 32'd1);
    endtask

    initial begin
        int   lat;
        exp_t e;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset arg_rdy", {31'b0, rdy8}, 32'd1);
        check("reset res_vld", {31'b0, rvld8}, 32'd0);
        check("reset quo", {24'b0, quo8}, 32'd0);
        check("reset rem", {24'b0, rem8}, 32'd0);
        check("reset div_by_zero", {31'b0, dz8}, 32'd0);
        check("reset n4 arg_rdy", {31'b0, rdy4}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases, n=8
        sel = 8;
        run(8'd200, 8'd7, 1'b0, "u200/7");
        run(8'hF9, 8'h02, 1'b1, "s-7/2");
        run(8'hF9, 8'h02, 1'b0, "u249/2");
        run(8'h80, 8'hFF, 1'b1, "s-128/-1");
        run(8'd100, 8'hF9, 1'b1, "s100/-7");
        run(8'd13, 8'd0, 1'b1, "s13/0");
        run(8'd13, 8'd0, 1'b0, "u13/0");
        run(8'hF3, 8'd0, 1'b1, "s-13/0");
        run(8'd5, 8'd9, 1'b0, "u5/9");
        run(8'hFF, 8'd1, 1'b0, "u255/1");

        // Backpressure: the result must hold while res_rdy is low and input activity is ignored
        rrdy8 = 1'b0;
        start(8'd77, 8'd3, 1'b0);
        wait_result(lat);
        check("bp latency", lat, 9);
        check_result("bp", e);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            sd8 = ~sd8;
            vld8 = (i % 2 == 0);
            @(posedge clk);
            #1;
            check("bp hold quo", {24'b0, quo8}, {24'b0, e.q});
            check("bp hold rem", {24'b0, rem8}, {24'b0, e.r});
            check("bp hold dz", {31'b0, dz8}, {31'b0, e.dz});
            check("bp hold res_vld", {31'b0, rvld8}, 32'd1);
            check("bp hold arg_rdy", {31'b0, rdy8}, 32'd0);
        end
        @(negedge clk);
        vld8 = 1'b0;
        rrdy8 = 1'b1;
        @(posedge clk);
        #1;
        check("bp handoff res_vld", {31'b0, rvld8}, 32'd0);
        check("bp handoff arg_rdy", {31'b0, rdy8}, 32'd1);
        @(posedge clk);
        #1;
        check("bp no second accept", {31'b0, rdy8}, 32'd1);

        // Asynchronous reset during BUSY cycle 4 drops the transaction
        start(8'hAB, 8'h03, 1'b0);
        @(posedge clk);
        #1;
        vld8 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset arg_rdy", {31'b0, rdy8}, 32'd1);
        check("midreset res_vld", {31'b0, rvld8}, 32'd0);
        check("midreset quo", {24'b0, quo8}, 32'd0);
        check("midreset rem", {24'b0, rem8}, 32'd0);
        check("midreset div_by_zero", {31'b0, dz8}, 32'd0);
        scb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run(8'd50, 8'd5, 1'b0, "post-reset 50/5");

        // Random scoreboard, n=8 then n=4
        for (int w = 8; w >= 4; w -= 4) begin
            sel = w;
            for (int i = 0; i < 25; i++) begin
                logic [7:0] ra, rb;
                ra = 8'($urandom);
                rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
                if (i == 0) begin
                    ra = (w == 8) ? 8'h80 : 8'h08;
                    rb = 8'hFF;
                end
                run(ra, rb, 1'($urandom), (w == 8) ? "rand n8" : "rand n4");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/signed_or_unsigned_div.md
Name: signed_or_unsigned_div

Overview:
- Iterative radix-2 integer divider; the inverse operation of the combinational signed/unsigned multiplier in the arithmetic block set.
- Accepts an N-bit dividend and an N-bit divisor plus a per-transaction signedness bit.
- Returns quotient and remainder through valid/ready handshakes on both sides.
- One quotient bit is produced per clock, for datapaths that cannot afford a combinational divider.

Parameters:
- n, 8, operand, quotient and remainder width in bits (n >= 2)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset; one clock domain, async assert, released synchronously to clk upstream
- arg_vld  input  1  dividend/divisor/signed_div valid
- arg_rdy  output  1  divider can accept a new transaction
- a  input  n  dividend
- b  input  n  divisor
- signed_div  input  1  1: a, b, quo, rem are two's complement; 0: unsigned
- res_vld  output  1  quo/rem/div_by_zero valid
- res_rdy  input  1  consumer accepts result
- quo  output  n  quotient
- rem  output  n  remainder
- div_by_zero  output  1  b was zero for this transaction

Behaviour:
- State machine: IDLE, BUSY, DONE.
  - IDLE: arg_rdy=1. arg_vld&&arg_rdy moves to BUSY.
    - On that edge, capture signed_div, the result signs, |a| and |b| (magnitudes are taken only when signed_div=1), and load the iteration counter with n-1.
  - BUSY: arg_rdy=0. Each cycle performs one restoring step: shift the remainder left by one and bring in the next dividend MSB; trial-subtract |b|; if non-negative, keep it and set the quotient bit to 1.
    - Counter decrements each cycle. Counter==0 moves to DONE.
    - Exactly n BUSY cycles.
  - DONE: res_vld=1, arg_rdy=0. res_vld&&res_rdy moves to IDLE.
    - Outputs hold stable while res_rdy=0 (no bubble, no change).
- Latency: result is visible n+1 cycles after the accept edge. Throughput is one transaction per n+2 cycles minimum with res_rdy tied high. No accept in the same cycle as result handoff.
- Sign rules when signed_div=1:
  - Quotient truncates toward zero; its sign is a[n-1]^b[n-1].
  - Remainder takes the sign of the dividend.
  - Invariant: a == quo*b + rem in n-bit two's complement.
  - Magnitudes are held in n bits. |most-negative| = 2^(n-1) fits unsigned.
- Width rule: the internal partial remainder is n+1 bits so the trial subtraction sign is visible. The final negate is applied on the last BUSY edge, so DONE outputs are registered.
- Divide by zero (b==0): normal n-cycle latency. quo = all ones (unsigned max, or -1 signed), rem = a unchanged, div_by_zero=1. Otherwise div_by_zero=0.
- Signed overflow (a = 100..0, b = all ones, signed_div=1): quo = 100..0, rem = 0, div_by_zero=0.
- Inputs a, b, signed_div are sampled only on the accept edge. Changes while BUSY/DONE are ignored.
- arg_vld while not in IDLE: ignored, no queuing.
- Reset values (any state, any time, including mid-BUSY): state=IDLE, arg_rdy=1, res_vld=0, quo=0, rem=0, div_by_zero=0, counter=0. An in-flight transaction is dropped silently.

Decomposition:
- Shared arithmetic package div_pkg holds:
  - state enum div_state_t {DIV_IDLE, DIV_BUSY, DIV_DONE}
  - helper function abs_n (conditional two's-complement negate)
- One sub-module is natural: udiv_step. It is combinational, takes the (n+1)-bit remainder, the dividend bit and the divisor, and returns the next remainder and the quotient bit. The top level keeps the FSM, counter, sign fix-up and handshakes.

Test Plan:
- n=8, unsigned 200/7, res_rdy=1 -> res_vld rises exactly 9 cycles after accept; quo=28, rem=4, div_by_zero=0; arg_rdy returns 1 the cycle after handoff.
- n=8, signed -7/2 (0xF9/0x02) -> quo=0xFD (-3), rem=0xFF (-1); the same bits with signed_div=0 (249/2) -> quo=124, rem=1.
- n=8, signed -128/-1 (0x80/0xFF) -> quo=0x80, rem=0x00, div_by_zero=0; signed 100/-7 -> quo=0xF2 (-14), rem=2.
- n=8, 13/0, signed and unsigned -> quo=0xFF, rem=13, div_by_zero=1, latency 9.
- Backpressure: hold res_rdy=0 for 5 cycles in DONE, toggle a/b/arg_vld -> outputs stable, arg_rdy=0, no second accept; res_rdy=1 then completes the handoff.
- Assert rst_n low at BUSY cycle 4 -> all outputs reset immediately (asynchronously); after release, a fresh 50/5 returns quo=10, rem=0. Bench also runs a random scoreboard against the reference a/b, a%b model for n=4 and n=8.
